// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front end.
//   FETCH_I_WIDTH  - default instruction width
//   FETCH_IA_WIDTH - default instruction address width
//   fetch_entry_s  - one queued instruction: its fetch address plus the word
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned FETCH_I_WIDTH  = 12;
    localparam int unsigned FETCH_IA_WIDTH = 8;
    localparam int unsigned FETCH_DEPTH    = 4;

    typedef struct packed {
        logic [FETCH_IA_WIDTH-1:0] addr;
        logic [FETCH_I_WIDTH-1:0]  instr;
    } fetch_entry_s;

    // Packs an address/instruction pair in the same {addr, instr} order used
    // by the queue storage.
    function automatic fetch_entry_s fetch_entry_make(
        input logic [FETCH_IA_WIDTH-1:0] addr,
        input logic [FETCH_I_WIDTH-1:0]  instr
    );
        fetch_entry_s e;
        e.addr  = addr;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular buffer of fetched instructions with push, pop and flush.
// Ports:
//   i_clk    - clock
//   i_rst    - asynchronous active-high reset; clears pointers, count, storage
//   i_push   - write i_data at the tail
//   i_data   - entry to write
//   i_pop    - advance the head; ignored while empty
//   i_flush  - empty the queue; overrides push and pop
//   o_head   - entry at the head
//   o_count  - current occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_IA_WIDTH + FETCH_I_WIDTH,
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // DEPTH is a power of two, so pointer wrap is the natural PW-bit overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Storage is left as-is; only the bookkeeping is reset.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Instruction fetch front end: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction memory and queues the returned words.
// Ports:
//   clk                 - clock
//   reset_i             - asynchronous active-high reset
//   deque_i             - backend pops the head entry (ignored while empty)
//   restart_i           - redirect: flush queue, drop in-flight read, load PC
//   restart_addr_i      - redirect target
//   imem_req_o          - read request this cycle
//   imem_addr_o         - read address (the PC)
//   imem_data_i         - read data, valid the cycle after the request
//   instruction_data_o  - head-entry instruction
//   instruction_addr_o  - head-entry address
//   instruction_ready_o - queue non-empty
//   count_o             - queue occupancy
// -----------------------------------------------------------------------------
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned I_WIDTH  = FETCH_I_WIDTH,
    parameter int unsigned IA_WIDTH = FETCH_IA_WIDTH,
    parameter int unsigned DEPTH    = FETCH_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    deque_i,
    input  logic                    restart_i,
    input  logic [IA_WIDTH-1:0]     restart_addr_i,
    output logic                    imem_req_o,
    output logic [IA_WIDTH-1:0]     imem_addr_o,
    input  logic [I_WIDTH-1:0]      imem_data_i,
    output logic [I_WIDTH-1:0]      instruction_data_o,
    output logic [IA_WIDTH-1:0]     instruction_addr_o,
    output logic                    instruction_ready_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = IA_WIDTH + I_WIDTH;

    logic [IA_WIDTH-1:0] r_pc;
    logic                r_pending;
    logic [IA_WIDTH-1:0] r_pending_addr;

    logic                w_issue;
    logic                w_push;
    logic [CW-1:0]       w_count;
    logic [CW:0]         w_inflight;
    logic [EW-1:0]       w_push_data;
    logic [EW-1:0]       w_head;

    // Counting the in-flight read reserves its slot, so the queue never overflows.
    assign w_inflight = {1'b0, w_count} + {{CW{1'b0}}, r_pending};
    assign w_issue    = !reset_i && !restart_i && (w_inflight < (CW+1)'(DEPTH));

    // A read still in flight during a restart belongs to the old stream.
    assign w_push      = r_pending && !restart_i;
    assign w_push_data = {r_pending_addr, imem_data_i};

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_pc           <= '0;
            r_pending      <= 1'b0;
            r_pending_addr <= '0;
        end else if (restart_i) begin
            r_pc      <= restart_addr_i;
            r_pending <= 1'b0;
        end else if (w_issue) begin
            r_pending      <= 1'b1;
            r_pending_addr <= r_pc;
            r_pc           <= r_pc + 1'b1;
        end else begin
            r_pending <= 1'b0;
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk   (clk),
        .i_rst   (reset_i),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (deque_i),
        .i_flush (restart_i),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_req_o          = w_issue;
    assign imem_addr_o         = r_pc;
    assign instruction_addr_o  = w_head[EW-1:I_WIDTH];
    assign instruction_data_o  = w_head[I_WIDTH-1:0];
    assign instruction_ready_o = (w_count != '0);
    assign count_o             = w_count;

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch
// Directed bench for fetch with a 1-cycle imem returning {4'hA, addr}.
// -----------------------------------------------------------------------------
module tb_fetch;
    import fetch_pkg::*;

    logic        clk;
    logic        reset_i;
    logic        deque_i;
    logic        restart_i;
    logic [7:0]  restart_addr_i;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic [11:0] imem_data_i;
    logic [11:0] instruction_data_o;
    logic [7:0]  instruction_addr_o;
    logic        instruction_ready_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    fetch #(
        .I_WIDTH  (12),
        .IA_WIDTH (8),
        .DEPTH    (4)
    ) dut (
        .clk                 (clk),
        .reset_i             (reset_i),
        .deque_i             (deque_i),
        .restart_i           (restart_i),
        .restart_addr_i      (restart_addr_i),
        .imem_req_o          (imem_req_o),
        .imem_addr_o         (imem_addr_o),
        .imem_data_i         (imem_data_i),
        .instruction_data_o  (instruction_data_o),
        .instruction_addr_o  (instruction_addr_o),
        .instruction_ready_o (instruction_ready_o),
        .count_o             (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous imem: one cycle latency, word = {4'hA, addr}.
    always @(posedge clk) imem_data_i <= {4'hA, imem_addr_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] a);
        fetch_entry_s e;
        e = fetch_entry_make(a, {4'hA, a});
        check({tag, ".ready"}, 32'(instruction_ready_o), 32'd1);
        check({tag, ".addr"},  32'(instruction_addr_o),  32'(e.addr));
        check({tag, ".data"},  32'(instruction_data_o),  32'(e.instr));
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".ready"}, 32'(instruction_ready_o), 32'd0);
        check({tag, ".count"}, 32'(count_o),             32'd0);
    endtask

    initial begin
        logic [7:0] wrap_seq [4];
        wrap_seq[0] = 8'hFE;
        wrap_seq[1] = 8'hFF;
        wrap_seq[2] = 8'h00;
        wrap_seq[3] = 8'h01;

        reset_i        = 1'b1;
        deque_i        = 1'b0;
        restart_i      = 1'b0;
        restart_addr_i = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(instruction_ready_o), 32'd0);
        check("rst.addr",  32'(instruction_addr_o),  32'd0);
        check("rst.data",  32'(instruction_data_o),  32'd0);
        check("rst.count", 32'(count_o),             32'd0);
        check("rst.req",   32'(imem_req_o),          32'd0);

        // Streaming with deque held high
        reset_i = 1'b0;
        deque_i = 1'b1;
        #1;
        check("st.req",   32'(imem_req_o),  32'd1);
        check("st.raddr", 32'(imem_addr_o), 32'd0);
        @(negedge clk);
        check("st.ready0", 32'(instruction_ready_o), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_head($sformatf("st%0d", k), 8'(k));
        end

        // Restart to 0x40 with a simultaneous pop while head is 5
        restart_i      = 1'b1;
        restart_addr_i = 8'h40;
        #1;
        check("rs.req_blocked", 32'(imem_req_o), 32'd0);
        @(negedge clk);
        restart_i = 1'b0;
        check_empty("rs.gap1");
        #1;
        check("rs.req",   32'(imem_req_o),  32'd1);
        check("rs.raddr", 32'(imem_addr_o), 32'h40);
        @(negedge clk);
        check_empty("rs.gap2");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_head($sformatf("rs%0d", k), 8'(8'h40 + k));
        end

        // Restart near the top of the address space: PC wraps
        restart_i      = 1'b1;
        restart_addr_i = 8'hFE;
        @(negedge clk);
        restart_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_head($sformatf("wr%0d", k), wrap_seq[k]);
        end

        // Async reset mid-stream with a read in flight
        #2;
        reset_i = 1'b1;
        #1;
        check("ar.ready", 32'(instruction_ready_o), 32'd0);
        check("ar.addr",  32'(instruction_addr_o),  32'd0);
        check("ar.data",  32'(instruction_data_o),  32'd0);
        check("ar.count", 32'(count_o),             32'd0);
        check("ar.req",   32'(imem_req_o),          32'd0);

        // Release with deque low: queue fills to 4, then issue stops
        @(negedge clk);
        reset_i = 1'b0;
        deque_i = 1'b0;
        repeat (10) @(negedge clk);
        check("fill.count", 32'(count_o),    32'd4);
        check("fill.req",   32'(imem_req_o), 32'd0);
        check_head("fill.head", 8'h00);

        // One pop re-enables issue for addr 4
        deque_i = 1'b1;
        @(negedge clk);
        deque_i = 1'b0;
        check("pop.count", 32'(count_o),     32'd3);
        check("pop.req",   32'(imem_req_o),  32'd1);
        check("pop.raddr", 32'(imem_addr_o), 32'd4);
        check_head("pop.head", 8'h01);
        @(negedge clk);
        check("pop.count_inflight", 32'(count_o),    32'd3);
        check("pop.req_off",        32'(imem_req_o), 32'd0);
        @(negedge clk);
        check("pop.count_full", 32'(count_o), 32'd4);

        // Pops while empty are ignored
        restart_i      = 1'b1;
        restart_addr_i = 8'h10;
        deque_i        = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        check_empty("ep.gap1");
        @(negedge clk);
        check_empty("ep.gap2");
        deque_i = 1'b0;
        @(negedge clk);
        check_head("ep.head", 8'h10);
        check("ep.count", 32'(count_o), 32'd1);
        @(negedge clk);
        check_head("ep.head_hold", 8'h10);
        check("ep.count2", 32'(count_o), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch front end for the 12-bit processor: owns the program counter, issues one read per cycle to a synchronous instruction memory, and buffers returned instructions in a small circular queue. It drives the instruction/address/ready triple that the backend consumes and honours the backend's `deque` pop and `restart` redirect. Sits between the instruction ROM and the backend in the processor top level.

## Interface
Parameters:
- `I_WIDTH`, 12, instruction width
- `IA_WIDTH`, 8, instruction address width
- `DEPTH`, 4, queue entries; power of two, at least 2

Ports:
- `clk` in 1, single clock, all state updates on its rising edge
- `reset_i` in 1, asynchronous active-high reset
- `deque_i` in 1, backend pops the head entry; ignored while `instruction_ready_o`=0
- `restart_i` in 1, backend redirect; flushes the queue and reloads the PC
- `restart_addr_i` in `IA_WIDTH`, redirect target, sampled when `restart_i`=1
- `imem_req_o` out 1, read request this cycle
- `imem_addr_o` out `IA_WIDTH`, read address, equals the PC
- `imem_data_i` in `I_WIDTH`, read data, valid the cycle after the request
- `instruction_data_o` out `I_WIDTH`, head-entry instruction
- `instruction_addr_o` out `IA_WIDTH`, head-entry address
- `instruction_ready_o` out 1, queue non-empty
- `count_o` out clog2(`DEPTH`)+1, current occupancy, for debug

## Operation
- State: `pc_r`, `pending_r` (one read in flight), `pending_addr_r`, queue storage, `head_r`, `tail_r`, `count_r`.
- Reset (async) clears all of the following: `pc_r`=0, `pending_r`=0, `head_r`=`tail_r`=0, `count_r`=0, and all storage entries to 0.
  - Resulting outputs: `instruction_ready_o`=0, data/addr outputs=0, `count_o`=0, `imem_req_o`=0 while `reset_i`=1.
- Issue condition is `!reset_i && !restart_i && (count_r + pending_r < DEPTH)`. `imem_req_o` is that condition, driven combinationally.
- On an issue edge:
  - `pending_r`<=1 and `pending_addr_r`<=`pc_r`.
  - `pc_r`<=`pc_r`+1, wrapping from 2^`IA_WIDTH`−1 to 0.
  - Otherwise `pending_r`<=0.
- Enqueue: on an edge with `pending_r`=1 and no restart, write {`pending_addr_r`, `imem_data_i`} at `tail_r`, then advance `tail_r` modulo `DEPTH`.
- Dequeue: on an edge with `deque_i`=1 and `count_r`>0, advance `head_r` modulo `DEPTH`.
- Count update: +1 on enqueue, −1 on dequeue, unchanged when both occur.
- Overflow is impossible by the issue rule. A pop when empty is a no-op.
- Restart has highest priority. On an edge with `restart_i`=1:
  - Queue is emptied (`head_r`=`tail_r`=0, `count_r`=0).
  - The in-flight read is discarded (`pending_r`<=0, its data never enqueued).
  - `pc_r`<=`restart_addr_i`.
  - Any simultaneous `deque_i` is absorbed; storage contents need not be cleared.
- Outputs `instruction_*_o` are driven from the entry at `head_r`. They are stable while `deque_i`=0.

## Timing
- Imem read latency is 1 cycle; enqueue happens on the edge ending the data cycle.
- After reset deassertion at edge E0:
  - Cycle after E0: `imem_req_o`=1, addr 0.
  - After E2: `instruction_ready_o`=1 with addr 0.
- Restart latency: if restart is sampled at edge E0, the target is requested in the cycle after E0 and presented (ready=1) after E2. `instruction_ready_o`=0 between E0 and E2.
- Steady state with `deque_i` held at 1: one instruction per cycle, in sequential address order.
- With `deque_i`=0: queue fills to `DEPTH`, then `imem_req_o`=0 until a pop. The first pop re-enables issue on the following cycle.
- Reset mid-operation: immediate return to the reset state, with no partial enqueue.

## Structure
- Shared package `fetch_pkg`: typedef `fetch_entry_s` {addr [`IA_WIDTH`], instr [`I_WIDTH`]}. Default widths 12/8 are constants there.
- Sub-module `fetch_queue`: parameterised circular buffer with push/pop/flush, head output, count.
- `fetch` adds the PC, in-flight tracking and the issue rule.

## Test plan
Imem model: 1-cycle latency, data = {4'hA, addr}.
- Reset, then `deque_i`=1 constantly → outputs (addr, data) of (0,0xA00), (1,0xA01), (2,0xA02)… on consecutive cycles, first ready after the second edge following reset release.
- `deque_i`=0 for 10 cycles after reset → `count_o` saturates at 4, `imem_req_o`=0. One pop → `count_o`=3, a request to addr 4 the next cycle, `count_o` back to 4.
- While streaming at addr 5, pulse `restart_i` with `restart_addr_i`=0x40 and `deque_i`=1 in the same cycle.
  - Ready drops for 2 cycles; next presented addr 0x40, data 0xA40.
  - No instruction from 6 or later appears.
- Restart to 0xFE and stream → addresses 0xFE, 0xFF, 0x00, 0x01 (PC wrap).
- Pulse `deque_i` while `instruction_ready_o`=0 → `count_o` stays 0, no underflow, and the next valid head is correct.
- Assert `reset_i` asynchronously mid-stream with a read in flight → outputs clear immediately. After release the stream restarts at addr 0 with no stale entry.
